// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_pkg;

  // Controller FSM states
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } hz_state_e;

  // EX-stage operand forwarding selects
  localparam logic [1:0] FWD_RF  = 2'b00;  // register file
  localparam logic [1:0] FWD_EX  = 2'b01;  // EX/MEM result
  localparam logic [1:0] FWD_MEM = 2'b10;  // MEM/WB result
  localparam logic [1:0] FWD_WB  = 2'b11;  // WB-write bypass

  // Pipeline-register load-enable bundle
  typedef struct packed {
    logic pc;
    logic if_id;
    logic id_ex;
    logic ex_mem;
    logic mem_wb;
  } pipe_le_t;

  localparam pipe_le_t LE_NONE = pipe_le_t'(5'b00000);
  localparam pipe_le_t LE_ALL  = pipe_le_t'(5'b11111);
  // Load-use bubble: front end holds, ID/EX takes the bubble, back end drains
  localparam pipe_le_t LE_LU   = pipe_le_t'(5'b00111);

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline status inputs and control outputs of the hazard controller.
interface hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] id_rs1, id_rs2;
  logic             id_use_rs1, id_use_rs2, id_branch_taken;
  logic [REG_W-1:0] ex_rd, mem_rd, wb_rd;
  logic             ex_rf_le, mem_rf_le, wb_rf_le;
  logic             ex_load, mem_req, mem_ack;
  logic             mux_s;
  logic             pc_le, if_id_le, id_ex_le, ex_mem_le, mem_wb_le;
  logic             if_id_clr;
  logic [1:0]       fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt;
  logic             halted;

  // Pipeline side: reports stage status, consumes control decisions
  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_branch_taken,
    output ex_rd, mem_rd, wb_rd, ex_rf_le, mem_rf_le, wb_rf_le,
    output ex_load, mem_req, mem_ack,
    input  mux_s, pc_le, if_id_le, id_ex_le, ex_mem_le, mem_wb_le,
    input  if_id_clr, fwd_a, fwd_b, stall_cnt, halted
  );

  // Controller side
  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_branch_taken,
    input  ex_rd, mem_rd, wb_rd, ex_rf_le, mem_rf_le, wb_rf_le,
    input  ex_load, mem_req, mem_ack,
    output mux_s, pc_le, if_id_le, id_ex_le, ex_mem_le, mem_wb_le,
    output if_id_clr, fwd_a, fwd_b, stall_cnt, halted
  );
endinterface

// File: rtl/hazard_ctrl_fwd_unit.sv
// Per-operand forwarding compare: picks the youngest stage writing the source.
module fwd_unit
  import hazard_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] src,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] mem_rd,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             ex_le,
  input  logic             mem_le,
  input  logic             wb_le,
  output logic             ex_hit,
  output logic [1:0]       sel
);

  logic mem_hit, wb_hit;

  // Stage match: stage writes the regfile, same register, and it is not x0
  always_comb begin
    ex_hit  = ex_le  && (ex_rd  == src) && (ex_rd  != '0);
    mem_hit = mem_le && (mem_rd == src) && (mem_rd != '0);
    wb_hit  = wb_le  && (wb_rd  == src) && (wb_rd  != '0);
  end

  // Priority select, youngest producer first
  always_comb begin
    if (ex_hit) begin
      sel = FWD_EX;
    end else if (mem_hit) begin
      sel = FWD_MEM;
    end else if (wb_hit) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use bubble, branch flush,
// memory-wait freeze with watchdog, forwarding selects, stall counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W      = 5,
  parameter int MAX_WAIT   = 255,
  parameter int CNT_W      = 16,
  parameter int DELAY_SLOT = 0
) (
  input logic           clk,
  input logic           reset,
  hazard_ctrl_if.slave  bus
);

  localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  hz_state_e         state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic       ex_hit_a, ex_hit_b;
  logic [1:0] fwd_a_raw, fwd_b_raw;
  logic       freeze, lu;
  pipe_le_t   le;
  logic       mux_s, if_id_clr;
  logic [1:0] fwd_a, fwd_b;

  fwd_unit #(.REG_W(REG_W)) u_fwd_a (
    .src    (bus.id_rs1),
    .ex_rd  (bus.ex_rd),
    .mem_rd (bus.mem_rd),
    .wb_rd  (bus.wb_rd),
    .ex_le  (bus.ex_rf_le),
    .mem_le (bus.mem_rf_le),
    .wb_le  (bus.wb_rf_le),
    .ex_hit (ex_hit_a),
    .sel    (fwd_a_raw)
  );

  fwd_unit #(.REG_W(REG_W)) u_fwd_b (
    .src    (bus.id_rs2),
    .ex_rd  (bus.ex_rd),
    .mem_rd (bus.mem_rd),
    .wb_rd  (bus.wb_rd),
    .ex_le  (bus.ex_rf_le),
    .mem_le (bus.mem_rf_le),
    .wb_le  (bus.wb_rf_le),
    .ex_hit (ex_hit_b),
    .sel    (fwd_b_raw)
  );

  // Hazard detection: outstanding memory access and load-use dependency
  always_comb begin
    freeze = bus.mem_req && !bus.mem_ack;
    lu     = bus.ex_load && ((bus.id_use_rs1 && ex_hit_a) ||
                             (bus.id_use_rs2 && ex_hit_b));
  end

  // State, watchdog and stall-counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next state: count consecutive wait cycles and trip the watchdog
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (freeze) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WAIT_ONE;
        end else begin
          wait_cnt_d = '0;
        end
      end
      ST_MEM_WAIT: begin
        if (!freeze) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_MAX) begin
          state_d = ST_HALT;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_ONE;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Saturating stall counter: freeze, load-use bubble or halted
  always_comb begin
    if ((freeze || lu || (state_q == ST_HALT)) && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Output decode: reset > halt > freeze > load-use > taken branch > run
  always_comb begin
    le        = LE_ALL;
    mux_s     = 1'b0;
    if_id_clr = 1'b0;
    fwd_a     = fwd_a_raw;
    fwd_b     = fwd_b_raw;
    if (reset) begin
      le        = LE_NONE;
      mux_s     = 1'b1;
      if_id_clr = 1'b1;
      fwd_a     = FWD_RF;
      fwd_b     = FWD_RF;
    end else if (state_q == ST_HALT) begin
      le    = LE_NONE;
      mux_s = 1'b1;
    end else if (freeze) begin
      le = LE_NONE;
    end else if (lu) begin
      // No flush here: the branch decision saw a stale operand
      le    = LE_LU;
      mux_s = 1'b1;
    end else if (bus.id_branch_taken && (DELAY_SLOT == 0)) begin
      if_id_clr = 1'b1;
    end else begin
      le = LE_ALL;
    end
  end

  assign bus.mux_s     = mux_s;
  assign bus.pc_le     = le.pc;
  assign bus.if_id_le  = le.if_id;
  assign bus.id_ex_le  = le.id_ex;
  assign bus.ex_mem_le = le.ex_mem;
  assign bus.mem_wb_le = le.mem_wb;
  assign bus.if_id_clr = if_id_clr;
  assign bus.fwd_a     = fwd_a;
  assign bus.fwd_b     = fwd_b;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed test-plan scenarios then random traffic.
module tb_hazard_ctrl;

  localparam int REG_W    = 5;
  localparam int MAX_WAIT = 3;
  localparam int CNT_W    = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) hif();

  hazard_ctrl #(
    .REG_W(REG_W), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W), .DELAY_SLOT(0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (hif.slave)
  );

  typedef struct {
    logic       rst;
    logic [4:0] rs1, rs2;
    logic       use1, use2, br;
    logic [4:0] exrd, memrd, wbrd;
    logic       exle, memle, wble;
    logic       ld, req, ack;
  } stim_t;

  // ctrl = {halted, mux_s, pc, if_id, id_ex, ex_mem, mem_wb, if_id_clr}
  typedef struct {
    logic [7:0]       ctrl;
    logic [1:0]       fa, fb;
    logic [CNT_W-1:0] stall;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  // Reference model state
  bit halted_m  = 1'b0;
  int wait_run  = 0;   // consecutive freeze cycles
  int stall_m   = 0;

  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b0; s.rs1 = 5'd0; s.rs2 = 5'd0;
    s.use1 = 1'b0; s.use2 = 1'b0; s.br = 1'b0;
    s.exrd = 5'd0; s.memrd = 5'd0; s.wbrd = 5'd0;
    s.exle = 1'b0; s.memle = 1'b0; s.wble = 1'b0;
    s.ld = 1'b0; s.req = 1'b0; s.ack = 1'b0;
    return s;
  endfunction

  function automatic bit writes(input logic le, input logic [4:0] rd, input logic [4:0] src);
    return le && (rd != 5'd0) && (rd == src);
  endfunction

  // Youngest stage that writes src wins; code is stage index + 1
  function automatic logic [1:0] fwd_model(input logic [4:0] src, input stim_t s);
    logic [4:0] rd [3];
    logic       le [3];
    rd[0] = s.exrd; rd[1] = s.memrd; rd[2] = s.wbrd;
    le[0] = s.exle; le[1] = s.memle; le[2] = s.wble;
    for (int i = 0; i < 3; i++) begin
      if (writes(le[i], rd[i], src)) return 2'(i + 1);
    end
    return 2'd0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  // Drive one cycle, push the expected response, advance the model
  task automatic step(input stim_t s);
    exp_t e;
    bit   lu, frz;
    @(posedge clk);
    #1;
    reset               = s.rst;
    hif.id_rs1          = s.rs1;  hif.id_rs2     = s.rs2;
    hif.id_use_rs1      = s.use1; hif.id_use_rs2 = s.use2;
    hif.id_branch_taken = s.br;
    hif.ex_rd  = s.exrd;  hif.mem_rd    = s.memrd; hif.wb_rd    = s.wbrd;
    hif.ex_rf_le = s.exle; hif.mem_rf_le = s.memle; hif.wb_rf_le = s.wble;
    hif.ex_load = s.ld;   hif.mem_req   = s.req;   hif.mem_ack  = s.ack;

    frz = s.req && !s.ack;
    lu  = s.ld && ((s.use1 && writes(s.exle, s.exrd, s.rs1)) ||
                   (s.use2 && writes(s.exle, s.exrd, s.rs2)));
    e.fa = fwd_model(s.rs1, s);
    e.fb = fwd_model(s.rs2, s);
    if (s.rst) begin
      e.ctrl = {halted_m, 1'b1, 5'b00000, 1'b1};
      e.fa = 2'd0; e.fb = 2'd0;
    end else if (halted_m)  e.ctrl = {1'b1, 1'b1, 5'b00000, 1'b0};
    else if (frz)           e.ctrl = {1'b0, 1'b0, 5'b00000, 1'b0};
    else if (lu)            e.ctrl = {1'b0, 1'b1, 5'b00111, 1'b0};
    else if (s.br)          e.ctrl = {1'b0, 1'b0, 5'b11111, 1'b1};
    else                    e.ctrl = {1'b0, 1'b0, 5'b11111, 1'b0};
    e.stall = CNT_W'(stall_m);
    exp_q.push_back(e);

    if (s.rst) begin
      halted_m = 1'b0; wait_run = 0; stall_m = 0;
    end else begin
      if ((frz || lu || halted_m) && stall_m < (1 << CNT_W) - 1) stall_m++;
      if (!halted_m) begin
        if (frz) begin
          wait_run++;
          if (wait_run == MAX_WAIT + 1) halted_m = 1'b1;
        end else begin
          wait_run = 0;
        end
      end
    end
  endtask

  // Monitor: compare the DUT's response away from the active edge
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("ctrl", 32'({hif.halted, hif.mux_s, hif.pc_le, hif.if_id_le, hif.id_ex_le,
                         hif.ex_mem_le, hif.mem_wb_le, hif.if_id_clr}), 32'(e.ctrl));
      check("fwd_a", 32'(hif.fwd_a), 32'(e.fa));
      check("fwd_b", 32'(hif.fwd_b), 32'(e.fb));
      check("stall_cnt", 32'(hif.stall_cnt), 32'(e.stall));
    end
  end

  initial begin
    stim_t s;
    // Unchecked preamble: bring the DUT to a known state
    s = idle();
    reset = 1'b1;
    hif.id_rs1 = 5'd0; hif.id_rs2 = 5'd0; hif.id_use_rs1 = 1'b0; hif.id_use_rs2 = 1'b0;
    hif.id_branch_taken = 1'b0; hif.ex_rd = 5'd0; hif.mem_rd = 5'd0; hif.wb_rd = 5'd0;
    hif.ex_rf_le = 1'b0; hif.mem_rf_le = 1'b0; hif.wb_rf_le = 1'b0;
    hif.ex_load = 1'b0; hif.mem_req = 1'b0; hif.mem_ack = 1'b0;
    repeat (2) @(posedge clk);

    // Reset-forced outputs
    s = idle(); s.rst = 1'b1; s.exle = 1'b1; s.exrd = 5'd3; s.rs1 = 5'd3;
    step(s);
    step(idle());

    // EX forwarding, EX beats MEM, x0 never matches
    s = idle(); s.exle = 1'b1; s.exrd = 5'd3; s.rs1 = 5'd3; s.use1 = 1'b1;
    step(s);
    s.memle = 1'b1; s.memrd = 5'd3;
    step(s);
    s.exrd = 5'd0;
    step(s);
    s = idle(); s.wble = 1'b1; s.wbrd = 5'd7; s.rs2 = 5'd7; s.rs1 = 5'd7;
    step(s);

    // Load-use: one bubble, then MEM forwarding
    s = idle(); s.ld = 1'b1; s.exle = 1'b1; s.exrd = 5'd5; s.rs2 = 5'd5; s.use2 = 1'b1;
    step(s);
    s = idle(); s.memle = 1'b1; s.memrd = 5'd5; s.rs2 = 5'd5; s.use2 = 1'b1;
    step(s);

    // Load-use coincident with taken branch: no flush, then flush on retake
    s = idle(); s.ld = 1'b1; s.exle = 1'b1; s.exrd = 5'd9; s.rs1 = 5'd9; s.use1 = 1'b1;
    s.br = 1'b1;
    step(s);
    s = idle(); s.memle = 1'b1; s.memrd = 5'd9; s.rs1 = 5'd9; s.use1 = 1'b1; s.br = 1'b1;
    step(s);
    step(idle());

    // Memory wait of 4 cycles
    s = idle(); s.req = 1'b1;
    repeat (4) step(s);
    s.ack = 1'b1;
    step(s);
    step(idle());

    // Watchdog timeout, then recovery by reset
    s = idle(); s.req = 1'b1;
    repeat (7) step(s);
    s = idle(); s.rst = 1'b1;
    step(s);
    step(idle());

    // Reset in the middle of a wait, then a full legal wait afterwards
    s = idle(); s.req = 1'b1;
    repeat (2) step(s);
    s.rst = 1'b1;
    step(s);
    s.rst = 1'b0;
    repeat (MAX_WAIT) step(s);
    s.ack = 1'b1;
    step(s);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      s.rst   = ($urandom_range(0, 39) == 0);
      s.rs1   = 5'($urandom_range(0, 3));
      s.rs2   = 5'($urandom_range(0, 3));
      s.use1  = 1'($urandom_range(0, 1));
      s.use2  = 1'($urandom_range(0, 1));
      s.br    = ($urandom_range(0, 3) == 0);
      s.exrd  = 5'($urandom_range(0, 3));
      s.memrd = 5'($urandom_range(0, 3));
      s.wbrd  = 5'($urandom_range(0, 3));
      s.exle  = 1'($urandom_range(0, 1));
      s.memle = 1'($urandom_range(0, 1));
      s.wble  = 1'($urandom_range(0, 1));
      s.ld    = 1'($urandom_range(0, 1));
      s.req   = ($urandom_range(0, 3) == 0);
      s.ack   = 1'($urandom_range(0, 1));
      step(s);
    end

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
